mgmt_master: RTL and testbench
==============================

Name: mgmt_master

Overview:
- Core-side master for the system management bus.
- Takes load/store commands from the core's system-access path and drives the mgmt_* request/ack/rxe protocol that sysreg and the other management slaves implement.
- Provides single-entry command buffering, a bus turnaround gap, and a timeout for undecoded addresses.
- Returns completion, read data and error status to the core.

Parameters:
TMO_W, 4, width of timeout counter; a request times out after 2^TMO_W-1 cycles without ack (default 15)
GAP, 2, minimum number of cycles mgmt_req stays low between two bus requests

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
cpu_req  input  1  command valid from core
cpu_rdy  output  1  command slot free; a command is accepted when cpu_req && cpu_rdy
cpu_adr  input  32  command address
cpu_rwn  input  1  1 = read, 0 = write
cpu_wen  input  2  write half-word enables
cpu_txd  input  32  write data
cpu_done  output  1  one-cycle completion pulse
cpu_err  output  1  valid with cpu_done; 1 = timeout (no slave acked)
cpu_rxd  output  32  read data; held until the next cpu_done
err_cnt  output  16  timeout event counter (optional feature)
mgmt_req  output  1  bus request, held high for the whole transfer
mgmt_adr  output  32  bus address, stable while mgmt_req is high
mgmt_rwn  output  1  bus read/write-not
mgmt_wen  output  2  bus write enables
mgmt_txd  output  32  bus write data
mgmt_ack  input  1  OR of all slave acks
mgmt_rxe  input  1  OR of all slave read-enables
mgmt_rxd  input  32  OR of all slave read data (each slave drives 0 when not rxe)

Behaviour:
- Reset values: all outputs 0 except cpu_rdy = 1. FSM = IDLE, pending slot empty, counters 0. Reset mid-transfer drops mgmt_req immediately.
- Command slot (depth 1):
  - cpu_rdy = !slot_valid.
  - An accepted command is latched into the slot; the core side never stalls a pulse.
- FSM states: IDLE, REQ, GAP.
- IDLE:
  - If slot_valid, load mgmt_adr/rwn/wen/txd from the slot, clear the slot, set mgmt_req = 1, clear the timeout counter, go to REQ.
  - Accept at edge c -> mgmt_req high after edge c+1. An accept and a launch from IDLE never occur in the same cycle.
- REQ:
  - mgmt_* fields are frozen; the timeout counter increments each cycle.
  - On mgmt_ack: capture mgmt_rxd into cpu_rxd if mgmt_rwn && mgmt_rxe, else leave cpu_rxd unchanged. Then pulse cpu_done = 1 with cpu_err = 0, drop mgmt_req, go to GAP. All of these updates happen at the same edge.
  - On counter == 2^TMO_W-1 without ack: cpu_done = 1, cpu_err = 1, cpu_rxd = 0, drop mgmt_req, go to GAP.
  - Ack and timeout in the same cycle: ack wins, no error.
- GAP:
  - mgmt_req stays low for GAP cycles, then the FSM goes to IDLE.
  - Ack/rxe arriving in GAP or IDLE (late slave) are ignored.
  - The slot may be refilled during REQ/GAP; it launches from IDLE on the following cycle.
- Nominal read to a sysreg-class slave:
  - cpu_req accepted at edge 0; mgmt_req high after edge 1.
  - Slave ack/rxe high after edge 3.
  - cpu_done/cpu_rxd valid after edge 4; mgmt_req low after edge 4.
- mgmt_txd drives 0 for reads.
- cpu_done is never asserted in two consecutive cycles.

Optional Feature:
- Macro MGMT_ERRCNT_EN.
- Defined: err_cnt increments by 1 on every timeout completion and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: err_cnt is tied to 0 and no counter flops exist.
- All other behaviour is identical with or without the macro.

Test Plan:
- Read, slave acks with rxe and rxd = 32'hDEADBEEF 2 cycles after mgmt_req rises -> cpu_done 1 cycle after ack, cpu_err = 0, cpu_rxd = 32'hDEADBEEF, mgmt_req low for exactly 2 cycles afterwards.
- Write to adr 32'h0000_0003, wen = 2'b11, txd = 32'h1234_5678, slave acks without rxe -> mgmt fields stable while req is high, cpu_done with cpu_err = 0, cpu_rxd unchanged.
- Read to an undecoded address, no ack -> cpu_done + cpu_err exactly 15 cycles after mgmt_req rises, cpu_rxd = 0. With MGMT_ERRCNT_EN, err_cnt = 1; an ack injected 2 cycles later is ignored.
- Back-to-back: two commands issued while the first is in REQ -> second accepted, cpu_rdy low until launch, second mgmt_req rises exactly GAP+1 cycles after the first drops; third cpu_req held off.
- Ack on the timeout-terminal cycle -> cpu_err = 0 and data captured.
- rst pulsed mid-REQ -> mgmt_req 0 immediately, cpu_rdy 1, no cpu_done. A fresh command completes normally after reset.

Source files
------------

// File: rtl/mgmt_master.sv
// mgmt_master: core-side master for the system management bus.
// Buffers one command from the core, drives the mgmt_* req/ack/rxe handshake,
// enforces a turnaround gap between requests and times out unacked requests.
// Optional feature: define MGMT_ERRCNT_EN to count timeout completions on err_cnt
// (saturating, cleared only by reset); otherwise err_cnt is tied to zero.
module mgmt_master #(
  parameter int TMO_W = 4,
  parameter int GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  output logic        cpu_rdy,
  input  logic [31:0] cpu_adr,
  input  logic        cpu_rwn,
  input  logic [1:0]  cpu_wen,
  input  logic [31:0] cpu_txd,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rxd,
  output logic [15:0] err_cnt,
  output logic        mgmt_req,
  output logic [31:0] mgmt_adr,
  output logic        mgmt_rwn,
  output logic [1:0]  mgmt_wen,
  output logic [31:0] mgmt_txd,
  input  logic        mgmt_ack,
  input  logic        mgmt_rxe,
  input  logic [31:0] mgmt_rxd
);

  localparam int                GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TMO_W-1:0]  TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [GW-1:0]     GAP_LAST = GW'(GAP - 1);
  localparam logic [GW-1:0]     GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state_r,      state_s;
  logic              slot_valid_r, slot_valid_s;
  logic [31:0]       slot_adr_r,   slot_adr_s;
  logic              slot_rwn_r,   slot_rwn_s;
  logic [1:0]        slot_wen_r,   slot_wen_s;
  logic [31:0]       slot_txd_r,   slot_txd_s;
  logic [TMO_W-1:0]  tmo_cnt_r,    tmo_cnt_s;
  logic [TMO_W-1:0]  tmo_inc_s;
  logic [GW-1:0]     gap_cnt_r,    gap_cnt_s;
  logic              mgmt_req_r,   mgmt_req_s;
  logic [31:0]       mgmt_adr_r,   mgmt_adr_s;
  logic              mgmt_rwn_r,   mgmt_rwn_s;
  logic [1:0]        mgmt_wen_r,   mgmt_wen_s;
  logic [31:0]       mgmt_txd_r,   mgmt_txd_s;
  logic              cpu_done_r,   cpu_done_s;
  logic              cpu_err_r,    cpu_err_s;
  logic [31:0]       cpu_rxd_r,    cpu_rxd_s;

  assign cpu_rdy  = ~slot_valid_r;
  assign cpu_done = cpu_done_r;
  assign cpu_err  = cpu_err_r;
  assign cpu_rxd  = cpu_rxd_r;
  assign mgmt_req = mgmt_req_r;
  assign mgmt_adr = mgmt_adr_r;
  assign mgmt_rwn = mgmt_rwn_r;
  assign mgmt_wen = mgmt_wen_r;
  assign mgmt_txd = mgmt_txd_r;

  // Next-state, command slot, bus fields and completion values
  always_comb begin
    state_s      = state_r;
    slot_valid_s = slot_valid_r;
    slot_adr_s   = slot_adr_r;
    slot_rwn_s   = slot_rwn_r;
    slot_wen_s   = slot_wen_r;
    slot_txd_s   = slot_txd_r;
    tmo_cnt_s    = tmo_cnt_r;
    tmo_inc_s    = tmo_cnt_r + TMO_ONE;
    gap_cnt_s    = gap_cnt_r;
    mgmt_req_s   = mgmt_req_r;
    mgmt_adr_s   = mgmt_adr_r;
    mgmt_rwn_s   = mgmt_rwn_r;
    mgmt_wen_s   = mgmt_wen_r;
    mgmt_txd_s   = mgmt_txd_r;
    cpu_done_s   = 1'b0;
    cpu_err_s    = 1'b0;
    cpu_rxd_s    = cpu_rxd_r;

    // Accept only into an empty slot, so an accept never meets a launch
    if (cpu_req && !slot_valid_r) begin
      slot_valid_s = 1'b1;
      slot_adr_s   = cpu_adr;
      slot_rwn_s   = cpu_rwn;
      slot_wen_s   = cpu_wen;
      slot_txd_s   = cpu_txd;
    end else begin
      slot_valid_s = slot_valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (slot_valid_r) begin
          mgmt_adr_s   = slot_adr_r;
          mgmt_rwn_s   = slot_rwn_r;
          mgmt_wen_s   = slot_wen_r;
          mgmt_txd_s   = slot_rwn_r ? 32'h0000_0000 : slot_txd_r;
          mgmt_req_s   = 1'b1;
          slot_valid_s = 1'b0;
          tmo_cnt_s    = {TMO_W{1'b0}};
          state_s      = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        tmo_cnt_s = tmo_inc_s;
        // Ack has priority over a timeout in the same cycle
        if (mgmt_ack) begin
          if (mgmt_rwn_r && mgmt_rxe) begin
            cpu_rxd_s = mgmt_rxd;
          end else begin
            cpu_rxd_s = cpu_rxd_r;
          end
          cpu_done_s = 1'b1;
          mgmt_req_s = 1'b0;
          gap_cnt_s  = {GW{1'b0}};
          state_s    = ST_GAP;
        end else if (tmo_inc_s == TMO_MAX) begin
          cpu_done_s = 1'b1;
          cpu_err_s  = 1'b1;
          cpu_rxd_s  = 32'h0000_0000;
          mgmt_req_s = 1'b0;
          gap_cnt_s  = {GW{1'b0}};
          state_s    = ST_GAP;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_ONE;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        mgmt_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops mgmt_req immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      slot_valid_r <= 1'b0;
      slot_adr_r   <= 32'h0000_0000;
      slot_rwn_r   <= 1'b0;
      slot_wen_r   <= 2'b00;
      slot_txd_r   <= 32'h0000_0000;
      tmo_cnt_r    <= {TMO_W{1'b0}};
      gap_cnt_r    <= {GW{1'b0}};
      mgmt_req_r   <= 1'b0;
      mgmt_adr_r   <= 32'h0000_0000;
      mgmt_rwn_r   <= 1'b0;
      mgmt_wen_r   <= 2'b00;
      mgmt_txd_r   <= 32'h0000_0000;
      cpu_done_r   <= 1'b0;
      cpu_err_r    <= 1'b0;
      cpu_rxd_r    <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      slot_valid_r <= slot_valid_s;
      slot_adr_r   <= slot_adr_s;
      slot_rwn_r   <= slot_rwn_s;
      slot_wen_r   <= slot_wen_s;
      slot_txd_r   <= slot_txd_s;
      tmo_cnt_r    <= tmo_cnt_s;
      gap_cnt_r    <= gap_cnt_s;
      mgmt_req_r   <= mgmt_req_s;
      mgmt_adr_r   <= mgmt_adr_s;
      mgmt_rwn_r   <= mgmt_rwn_s;
      mgmt_wen_r   <= mgmt_wen_s;
      mgmt_txd_r   <= mgmt_txd_s;
      cpu_done_r   <= cpu_done_s;
      cpu_err_r    <= cpu_err_s;
      cpu_rxd_r    <= cpu_rxd_s;
    end
  end

`ifdef MGMT_ERRCNT_EN
  logic        tmo_hit_s;
  logic [15:0] err_cnt_r;

  assign tmo_hit_s = (state_r == ST_REQ) && !mgmt_ack && (tmo_inc_s == TMO_MAX);
  assign err_cnt   = err_cnt_r;

  // Saturating count of timeout completions, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= 16'h0000;
    end else if (tmo_hit_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mgmt_master.sv
// tb_mgmt_master: randomized self-checking bench for mgmt_master.
// A transaction-level model predicts completion latency, error and read data
// from the slave latency chosen for each transaction.
module tb_mgmt_master;

  localparam int TMO_W   = 4;
  localparam int GAP     = 2;
  localparam int TMO_LIM = (1 << TMO_W) - 1;
  localparam int NO_ACK  = 1000;

  typedef struct {
    logic [31:0] adr;
    logic        rwn;
    logic [1:0]  wen;
    logic [31:0] txd;
    int          lat;
    logic        rxe;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_rdy;
  logic [31:0] cpu_adr;
  logic        cpu_rwn;
  logic [1:0]  cpu_wen;
  logic [31:0] cpu_txd;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rxd;
  logic [15:0] err_cnt;
  logic        mgmt_req;
  logic [31:0] mgmt_adr;
  logic        mgmt_rwn;
  logic [1:0]  mgmt_wen;
  logic [31:0] mgmt_txd;
  logic        mgmt_ack;
  logic        mgmt_rxe;
  logic [31:0] mgmt_rxd;

  mgmt_master #(.TMO_W(TMO_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rdy(cpu_rdy), .cpu_adr(cpu_adr), .cpu_rwn(cpu_rwn),
    .cpu_wen(cpu_wen), .cpu_txd(cpu_txd), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rxd(cpu_rxd), .err_cnt(err_cnt),
    .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_rwn(mgmt_rwn), .mgmt_wen(mgmt_wen),
    .mgmt_txd(mgmt_txd), .mgmt_ack(mgmt_ack), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  txn_t        pend_q[$];
  txn_t        act;
  bit          act_valid = 1'b0;
  txn_t        drv_txn;
  int          rise_cyc = 0;
  int          rise_log[$];
  int          done_log[$];
  int          acc_log[$];
  logic        prev_req  = 1'b0;
  logic        prev_done = 1'b0;
  bit          stable_bad = 1'b0;
  bit          inject_ack = 1'b0;
  logic [31:0] model_rxd = 32'h0;
  int          model_errs = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_err_cnt(input int errs);
`ifdef MGMT_ERRCNT_EN
    return (errs > 65535) ? 32'h0000_FFFF : 32'(errs);
`else
    return (errs < 0) ? 32'hFFFF_FFFF : 32'h0;
`endif
  endfunction

  function automatic txn_t mk(input logic [31:0] adr, input logic rwn, input logic [1:0] wen,
                              input logic [31:0] txd, input int lat, input logic rxe,
                              input logic [31:0] dat);
    txn_t t;
    t.adr = adr; t.rwn = rwn; t.wen = wen; t.txd = txd;
    t.lat = lat; t.rxe = rxe; t.dat = dat;
    return t;
  endfunction

  // One clock: advance, observe the bus and completions, play the slave
  task automatic tick();
    bit acc;
    bit acked;
    int exp_lat;
    acc = (cpu_req === 1'b1) && (cpu_rdy === 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      pend_q.push_back(drv_txn);
      acc_log.push_back(cyc);
    end
    if (mgmt_req === 1'b1 && prev_req !== 1'b1) begin
      if (pend_q.size() == 0) begin
        check_eq("spurious_req", 32'd1, 32'd0);
      end else begin
        act        = pend_q.pop_front();
        act_valid  = 1'b1;
        rise_cyc   = cyc;
        stable_bad = 1'b0;
        rise_log.push_back(cyc);
      end
    end
    if (mgmt_req === 1'b1 && act_valid) begin
      if (mgmt_adr !== act.adr || mgmt_rwn !== act.rwn || mgmt_wen !== act.wen ||
          mgmt_txd !== (act.rwn ? 32'h0 : act.txd))
        stable_bad = 1'b1;
    end
    mgmt_ack = 1'b0;
    mgmt_rxe = 1'b0;
    mgmt_rxd = 32'h0;
    if (mgmt_req === 1'b1 && act_valid && (cyc - rise_cyc) >= act.lat) begin
      mgmt_ack = 1'b1;
      mgmt_rxe = act.rxe;
      mgmt_rxd = act.rxe ? act.dat : 32'h0;
    end
    if (inject_ack) begin
      mgmt_ack   = 1'b1;
      mgmt_rxe   = 1'b1;
      mgmt_rxd   = 32'hBAD0_BAD0;
      inject_ack = 1'b0;
    end
    if (cpu_done === 1'b1) begin
      check_eq("done_gap", {31'd0, prev_done}, 32'd0);
      if (!act_valid) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        acked   = (act.lat + 1) <= TMO_LIM;
        exp_lat = acked ? act.lat + 1 : TMO_LIM;
        if (!acked) begin
          model_rxd = 32'h0;
          model_errs++;
        end else if (act.rwn && act.rxe) begin
          model_rxd = act.dat;
        end
        check_eq("done_lat", 32'(cyc - rise_cyc), 32'(exp_lat));
        check_eq("cpu_err", {31'd0, cpu_err}, {31'd0, !acked});
        check_eq("cpu_rxd", cpu_rxd, model_rxd);
        check_eq("bus_fields", {31'd0, stable_bad}, 32'd0);
        check_eq("err_cnt", {16'd0, err_cnt}, exp_err_cnt(model_errs));
        act_valid = 1'b0;
        done_log.push_back(cyc);
      end
    end
    prev_req  = mgmt_req;
    prev_done = cpu_done;
  endtask

  task automatic issue(input txn_t t);
    int n;
    drv_txn = t;
    cpu_adr = t.adr; cpu_rwn = t.rwn; cpu_wen = t.wen; cpu_txd = t.txd;
    cpu_req = 1'b1;
    n = acc_log.size();
    for (int i = 0; i < 60 && acc_log.size() == n; i++) tick();
    if (acc_log.size() == n) check_eq("accept_wait", 32'd0, 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic wait_txns();
    int i;
    i = 0;
    while ((act_valid || pend_q.size() != 0) && i < 200) begin
      tick();
      i++;
    end
    if (act_valid || pend_q.size() != 0) check_eq("done_wait", 32'd0, 32'd1);
  endtask

  initial begin
    txn_t t;
    int   n0;
    int   nr;
    int   nd;
    rst = 1'b1; cpu_req = 1'b0; cpu_adr = 32'h0; cpu_rwn = 1'b0; cpu_wen = 2'b00;
    cpu_txd = 32'h0; mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", {31'd0, mgmt_req}, 32'd0);
    check_eq("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
    check_eq("rst_done", {31'd0, cpu_done}, 32'd0);
    check_eq("rst_err", {31'd0, cpu_err}, 32'd0);
    check_eq("rst_rxd", cpu_rxd, 32'h0);
    check_eq("rst_errcnt", {16'd0, err_cnt}, 32'h0);
    check_eq("rst_adr", mgmt_adr, 32'h0);
    check_eq("rst_txd", mgmt_txd, 32'h0);
    rst = 1'b0;
    repeat (2) tick();

    // Nominal read, ack two cycles after the request rises
    issue(mk(32'h0000_0010, 1'b1, 2'b00, 32'hFFFF_FFFF, 2, 1'b1, 32'hDEAD_BEEF));
    wait_txns();
    check_eq("launch_lat", 32'(rise_log[$] - acc_log[$]), 32'd1);
    check_eq("rd_rxd", cpu_rxd, 32'hDEAD_BEEF);
    for (int i = 0; i < GAP; i++) begin
      tick();
      check_eq("gap_low", {31'd0, mgmt_req}, 32'd0);
    end

    // Write without rxe leaves read data untouched
    issue(mk(32'h0000_0003, 1'b0, 2'b11, 32'h1234_5678, 3, 1'b0, 32'h0));
    wait_txns();
    check_eq("wr_rxd_hold", cpu_rxd, 32'hDEAD_BEEF);
    repeat (GAP + 1) tick();

    // Undecoded address, followed by a late ack that must be ignored
    issue(mk(32'hFFFF_0000, 1'b1, 2'b00, 32'h0, NO_ACK, 1'b1, 32'h5555_AAAA));
    wait_txns();
    check_eq("tmo_lat", 32'(done_log[$] - rise_log[$]), 32'd15);
    check_eq("tmo_err", {31'd0, cpu_err}, 32'd1);
    n0 = done_log.size();
    tick();
    inject_ack = 1'b1;
    repeat (4) tick();
    check_eq("late_ack", 32'(done_log.size() - n0), 32'd0);
    check_eq("late_rxd", cpu_rxd, 32'h0);

    // Back-to-back: second buffered during REQ, third held off
    issue(mk(32'h0000_0100, 1'b1, 2'b00, 32'h0, 6, 1'b1, 32'h0A0A_0A0A));
    tick();
    issue(mk(32'h0000_0104, 1'b0, 2'b01, 32'hC0DE_0001, 3, 1'b0, 32'h0));
    check_eq("rdy_full", {31'd0, cpu_rdy}, 32'd0);
    t = mk(32'h0000_0108, 1'b1, 2'b10, 32'h0, 4, 1'b1, 32'h7777_1111);
    issue(t);
    wait_txns();
    nr = rise_log.size();
    nd = done_log.size();
    check_eq("b2b_gap1", 32'(rise_log[nr-2] - done_log[nd-3]), 32'(GAP + 1));
    check_eq("b2b_gap2", 32'(rise_log[nr-1] - done_log[nd-2]), 32'(GAP + 1));
    check_eq("b2b_hold", 32'(acc_log[$] - rise_log[nr-2]), 32'd1);
    repeat (GAP + 1) tick();

    // Ack on the timeout-terminal cycle wins
    issue(mk(32'h0000_0040, 1'b1, 2'b00, 32'h0, TMO_LIM - 1, 1'b1, 32'hCAFE_F00D));
    wait_txns();
    check_eq("term_lat", 32'(done_log[$] - rise_log[$]), 32'(TMO_LIM));
    check_eq("term_rxd", cpu_rxd, 32'hCAFE_F00D);
    repeat (GAP + 1) tick();

    // Reset in the middle of a request
    issue(mk(32'h0000_0200, 1'b1, 2'b00, 32'h0, NO_ACK, 1'b0, 32'h0));
    repeat (4) tick();
    check_eq("pre_rst_req", {31'd0, mgmt_req}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", {31'd0, mgmt_req}, 32'd0);
    check_eq("mid_rst_rdy", {31'd0, cpu_rdy}, 32'd1);
    check_eq("mid_rst_done", {31'd0, cpu_done}, 32'd0);
    act_valid = 1'b0;
    pend_q.delete();
    model_rxd = 32'h0;
    model_errs = 0;
    prev_req = 1'b0;
    prev_done = 1'b0;
    repeat (2) begin
      tick();
      check_eq("rst_hold_done", {31'd0, cpu_done}, 32'd0);
    end
    check_eq("rst_errcnt2", {16'd0, err_cnt}, 32'h0);
    rst = 1'b0;
    tick();
    issue(mk(32'h0000_0300, 1'b1, 2'b00, 32'h0, 4, 1'b1, 32'h1357_9BDF));
    wait_txns();
    repeat (GAP + 1) tick();

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      t.adr = $urandom;
      t.rwn = 1'($urandom_range(0, 1));
      t.wen = 2'($urandom_range(0, 3));
      t.txd = $urandom;
      t.lat = ($urandom_range(0, 5) == 0) ? NO_ACK : int'($urandom_range(1, 16));
      t.rxe = 1'($urandom_range(0, 1));
      t.dat = $urandom;
      issue(t);
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_txns();
    repeat (GAP + 1) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
